// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch stage for the 16-bit single-cycle datapath.
// Owns the PC, drives the combinational instruction-memory address, buffers
// fetched {pc, instr} pairs in a small FIFO and presents the head to decode
// over a valid/ready handshake. A branch redirect flushes the queue and
// reloads the PC.
// Optional feature macro: FETCH_HALT_EN (fetch stops after an opcode 4'hF).
module fetch_queue_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               Clear,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_next,
    output logic [15:0]        fetch_count,
    output logic               halted
);

    localparam int             AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  LP_DEPTH = CW'(QDEPTH);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_q_pc    [QDEPTH];
    logic [INSTR_W-1:0] r_q_instr [QDEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_fetch_count;

    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_halted;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && id_ready;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign w_push  = !w_halted && !br_taken && ((r_count < LP_DEPTH) || w_pop);

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;
    assign halted      = w_halted;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halt_op;

    assign w_halt_op = (imem_data[INSTR_W-1 -: 4] == 4'hF);

    // Halt latches when an opcode-F instruction is pushed; only Clear or a redirect releases it.
    always_ff @(posedge clk) begin
        if (Clear) begin
            r_halted <= 1'b0;
        end else if (br_taken) begin
            r_halted <= 1'b0;
        end else if (w_push && w_halt_op) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    // Queue storage: written on push, read through the head pointer.
    // NOTE: storage is deliberately not reset; the head is only exposed when
    // the occupancy count says it is valid, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (w_push && !Clear) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= imem_data;
        end
    end

    // PC, queue pointers, occupancy and accepted-instruction counter.
    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values of w_push/w_pop and of each other.
    always_ff @(posedge clk) begin
        if (Clear) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_fetch_count <= '0;
        end else begin
            // A pop in the redirect cycle still counts as accepted by decode.
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end

            if (br_taken) begin
                r_pc     <= br_target;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + PC_W'(1);
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Head presentation: zeros whenever the queue is empty.
    // NOTE: defaults are assigned first so no path through the block leaves
    // an output unassigned, which would otherwise infer a latch.
    always_comb begin
        id_valid   = w_valid;
        id_instr   = '0;
        id_pc      = '0;
        id_pc_next = '0;
        if (w_valid) begin
            id_instr   = r_q_instr[r_rd_ptr];
            id_pc      = r_q_pc[r_rd_ptr];
            id_pc_next = r_q_pc[r_rd_ptr] + PC_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for fetch_queue_unit. A second instance
// with RESET_PC=16'hFFFE covers PC wrap-around. Halt checks follow
// FETCH_HALT_EN.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        clear;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_next;
    logic [15:0] fetch_count;
    logic        halted;
    logic        halt_mode;

    // Wrap instance (RESET_PC = 16'hFFFE)
    logic        wr_clear;
    logic [15:0] wr_imem_addr;
    logic [15:0] wr_imem_data;
    logic        wr_valid;
    logic [15:0] wr_instr;
    logic [15:0] wr_pc;
    logic [15:0] wr_pc_next;
    logic [15:0] wr_fetch_count;
    logic        wr_halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue_unit u_dut (
        .clk         (clk),
        .Clear       (clear),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_next  (id_pc_next),
        .fetch_count (fetch_count),
        .halted      (halted)
    );

    fetch_queue_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk         (clk),
        .Clear       (wr_clear),
        .imem_addr   (wr_imem_addr),
        .imem_data   (wr_imem_data),
        .br_taken    (1'b0),
        .br_target   (16'h0000),
        .id_ready    (1'b1),
        .id_valid    (wr_valid),
        .id_instr    (wr_instr),
        .id_pc       (wr_pc),
        .id_pc_next  (wr_pc_next),
        .fetch_count (wr_fetch_count),
        .halted      (wr_halted)
    );

    // Instruction memory: mem[i] = 16'h1000 + i, with an optional halt opcode at address 2.
    always_comb begin
        imem_data = 16'h1000 + imem_addr;
        if (halt_mode && imem_addr == 16'd2) begin
            imem_data = 16'hF000;
        end
    end
    assign wr_imem_data = 16'h1000 + wr_imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear     = 1'b1;
        wr_clear  = 1'b1;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        id_ready  = 1'b1;
        halt_mode = 1'b0;

        // Reset state after two Clear cycles
        step();
        step();
        check("rst_valid",   id_valid,    0);
        check("rst_instr",   id_instr,    0);
        check("rst_pc",      id_pc,       0);
        check("rst_pc_next", id_pc_next,  0);
        check("rst_count",   fetch_count, 0);
        check("rst_addr",    imem_addr,   0);
        check("rst_halted",  halted,      0);

        // Free streaming: head valid one cycle after Clear drops, 1 instr/cycle
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stream_valid", id_valid, 1);
            check("stream_pc",    id_pc,    32'(k));
            check("stream_instr", id_instr, 32'(16'h1000 + 16'(k)));
        end
        step();
        check("stream_count5", fetch_count, 5);

        // Backpressure: id_ready low for 4 cycles after the first valid
        clear    = 1'b1;
        id_ready = 1'b0;
        step();
        clear = 1'b0;
        step();                                   // cycle 1
        check("bp_first_valid", id_valid, 1);
        check("bp_first_pc",    id_pc,    0);
        step();                                   // cycle 2
        check("bp_addr_c2", imem_addr, 2);
        step();
        step();                                   // cycle 4
        check("bp_addr_c4", imem_addr, 2);
        check("bp_hold_pc", id_pc,     0);
        check("bp_count",   fetch_count, 0);
        step();                                   // cycle 5
        check("bp_hold_pc5", id_pc, 0);
        id_ready = 1'b1;
        step();                                   // cycle 6
        check("bp_drain_pc1", id_pc, 1);
        step();                                   // cycle 7
        check("bp_drain_pc2",  id_pc,       2);
        check("bp_drain_cnt",  fetch_count, 2);
        step();                                   // cycle 8
        check("bp_drain_pc3", id_pc, 3);

        // Redirect at id_pc=3 to 16'h0020
        br_taken  = 1'b1;
        br_target = 16'h0020;
        step();                                   // cycle 9
        br_taken = 1'b0;
        check("br_flush_valid", id_valid,    0);
        check("br_addr",        imem_addr,   16'h0020);
        check("br_pop_counted", fetch_count, 4);
        step();                                   // cycle 10
        check("br_tgt_valid",   id_valid,   1);
        check("br_tgt_pc",      id_pc,      16'h0020);
        check("br_tgt_pc_next", id_pc_next, 16'h0021);
        check("br_tgt_instr",   id_instr,   16'h1020);
        step();                                   // cycle 11
        check("br_next_pc", id_pc, 16'h0021);

        // Fill the queue under backpressure, then Clear mid-stream
        id_ready = 1'b0;
        step();
        step();                                   // cycle 13, queue full
        check("full_hold_pc", id_pc,       16'h0021);
        check("full_count",   fetch_count, 5);
        clear = 1'b1;
        step();
        check("mid_clr_valid", id_valid,    0);
        check("mid_clr_count", fetch_count, 0);
        check("mid_clr_addr",  imem_addr,   0);
        check("mid_clr_pc",    id_pc,       0);
        check("mid_clr_instr", id_instr,    0);

        // PC wrap on the RESET_PC=16'hFFFE instance
        wr_clear = 1'b0;
        step();
        check("wrap_valid",    wr_valid,   1);
        check("wrap_pc0",      wr_pc,      16'hFFFE);
        check("wrap_next0",    wr_pc_next, 16'hFFFF);
        check("wrap_instr0",   wr_instr,   16'h0FFE);
        step();
        check("wrap_pc1",      wr_pc,      16'hFFFF);
        check("wrap_next1",    wr_pc_next, 16'h0000);
        step();
        check("wrap_pc2",      wr_pc,      16'h0000);
        check("wrap_next2",    wr_pc_next, 16'h0001);

        // Opcode 4'hF at address 2
        halt_mode = 1'b1;
        id_ready  = 1'b1;
        step();                                   // Clear still high
        clear = 1'b0;
        step();
        step();
        step();                                   // cycle 3
        check("halt_op_pc",    id_pc,     2);
        check("halt_op_instr", id_instr,  16'hF000);
        check("halt_op_addr",  imem_addr, 3);
`ifdef FETCH_HALT_EN
        check("halt_set", halted, 1);
        step();                                   // cycle 4
        check("halt_no_valid", id_valid,  0);
        check("halt_addr_hold", imem_addr, 3);
        check("halt_stays",    halted,    1);
        step();                                   // cycle 5
        check("halt_no_valid5", id_valid, 0);
        br_taken  = 1'b1;
        br_target = 16'h0000;
        step();                                   // cycle 6
        br_taken = 1'b0;
        check("resume_halted", halted,    0);
        check("resume_valid0", id_valid,  0);
        check("resume_addr",   imem_addr, 0);
        step();                                   // cycle 7
        check("resume_valid", id_valid, 1);
        check("resume_pc",    id_pc,    0);
        check("resume_instr", id_instr, 16'h1000);
`else
        check("nohalt_halted", halted, 0);
        step();                                   // cycle 4
        check("nohalt_valid", id_valid,  1);
        check("nohalt_pc",    id_pc,     3);
        check("nohalt_addr",  imem_addr, 4);
        check("nohalt_tied",  halted,    0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
